// File: rtl/modn_counter.sv
// Modulo-N up/down counter digit with load clamping, wrap/stop modes and a
// sticky done flag; digits cascade through tc -> enable.
module modn_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 6,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             loadn,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             up,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             at_max,
  output logic             done
);

  // MODULUS-1 fits in WIDTH bits even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RSTV  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZEROV = '0;

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RESET_VALUE < 0 ||
        RESET_VALUE >= MODULUS) begin : g_bad_params
      $error("modn_counter: illegal MODULUS/RESET_VALUE for this WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] term;
  logic             at_term;
  logic [WIDTH-1:0] load_value;

  assign term       = up ? TOP : ZEROV;
  assign at_term    = (count == term);
  assign load_value = (data > TOP) ? TOP : data;

  assign tc     = enable & wrap & at_term;
  assign zero   = (count == ZEROV);
  assign at_max = (count == TOP);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      count <= RSTV;
      done  <= 1'b0;
    end else if (!loadn) begin
      count <= load_value;
      done  <= 1'b0;
    end else if (enable) begin
      if (!at_term) begin
        count <= up ? (count + ONE) : (count - ONE);
      end else if (wrap) begin
        count <= up ? ZEROV : TOP;
      end else begin
        // Stop mode: park on the terminal value and latch done.
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_modn_counter.sv
// Scoreboard bench for modn_counter: single digits, a two-digit cascade and
// an async-reset variant with RESET_VALUE=2.
module tb_modn_counter;
  logic       clock = 1'b0;
  logic       clrn = 1'b0, clrn2 = 1'b0;
  logic       loadn = 1'b1, enable = 1'b0, up = 1'b0, wrap = 1'b1;
  logic       loadn_c = 1'b1, cen = 1'b0;
  logic [3:0] data = 4'd0, data_u = 4'd0, data_t = 4'd0;

  logic [3:0] count, count2, cu, ct;
  logic       tc, zero, at_max, done;
  logic       tc2, zero2, at_max2, done2;
  logic       tcu, zu, mu, du, tct, zt, mt, dt;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  logic [7:0] obs;

  modn_counter #(.WIDTH(4), .MODULUS(6), .RESET_VALUE(0)) dut (
    .clock(clock), .clrn(clrn), .loadn(loadn), .data(data), .enable(enable),
    .up(up), .wrap(wrap), .count(count), .tc(tc), .zero(zero),
    .at_max(at_max), .done(done));

  modn_counter #(.WIDTH(4), .MODULUS(6), .RESET_VALUE(2)) dut2 (
    .clock(clock), .clrn(clrn2), .loadn(loadn), .data(data), .enable(enable),
    .up(up), .wrap(wrap), .count(count2), .tc(tc2), .zero(zero2),
    .at_max(at_max2), .done(done2));

  modn_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) units (
    .clock(clock), .clrn(clrn), .loadn(loadn_c), .data(data_u), .enable(cen),
    .up(up), .wrap(wrap), .count(cu), .tc(tcu), .zero(zu),
    .at_max(mu), .done(du));

  modn_counter #(.WIDTH(4), .MODULUS(6), .RESET_VALUE(0)) tens (
    .clock(clock), .clrn(clrn), .loadn(loadn_c), .data(data_t), .enable(tcu),
    .up(up), .wrap(wrap), .count(ct), .tc(tct), .zero(zt),
    .at_max(mt), .done(dt));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected {count, tc, zero, at_max, done} for a mod-6 digit.
  function automatic logic [7:0] mk(input logic [3:0] c, input logic t, input logic d);
    return {c, t, c == 4'd0, c == 4'd5, d};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; up = 1'b0; wrap = 1'b1; enable = 1'b1; loadn = 1'b1;
    exp_q.push_back(mk(4'd0, 1'b1, 1'b0));
    #2;
    e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
    if (obs !== e) $display("FAIL reset: got %h want %h", obs, e);
    else passed++;
    tick();
    clrn = 1'b1;
  endtask

  task automatic test_down_wrap();
    int seq[7] = '{5, 4, 3, 2, 1, 0, 5};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(mk(4'(seq[i]), seq[i] == 0, 1'b0));
      tick();
      #1;
      e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
      if (obs !== e) $display("FAIL down_wrap[%0d]: got %h want %h", i, obs, e);
      else passed++;
    end
  endtask

  task automatic test_up_wrap();
    int seq[4] = '{4, 5, 0, 1};
    up = 1'b1; wrap = 1'b1; loadn = 1'b0; data = 4'd3;
    exp_q.push_back(mk(4'd3, 1'b0, 1'b0));
    tick();
    loadn = 1'b1;
    #1;
    e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
    if (obs !== e) $display("FAIL up_load3: got %h want %h", obs, e);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(4'(seq[i]), seq[i] == 5, 1'b0));
      tick();
      #1;
      e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
      if (obs !== e) $display("FAIL up_wrap[%0d]: got %h want %h", i, obs, e);
      else passed++;
    end
  endtask

  task automatic test_load_clamp();
    loadn = 1'b0; data = 4'd9; enable = 1'b1;
    exp_q.push_back(mk(4'd5, 1'b0, 1'b0));
    tick();
    loadn = 1'b1; enable = 1'b0;
    #1;
    e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
    if (obs !== e) $display("FAIL load_clamp: got %h want %h", obs, e);
    else passed++;
    exp_q.push_back(mk(4'd5, 1'b0, 1'b0));
    tick();
    #1;
    e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
    if (obs !== e) $display("FAIL hold: got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_stop_done();
    int cs[4] = '{1, 0, 0, 0};
    int ds[4] = '{0, 0, 1, 1};
    up = 1'b0; wrap = 1'b0; enable = 1'b1; loadn = 1'b0; data = 4'd2;
    exp_q.push_back(mk(4'd2, 1'b0, 1'b0));
    tick();
    loadn = 1'b1;
    #1;
    e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
    if (obs !== e) $display("FAIL stop_load2: got %h want %h", obs, e);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(4'(cs[i]), 1'b0, ds[i] != 0));
      tick();
      #1;
      e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
      if (obs !== e) $display("FAIL stop[%0d]: got %h want %h", i, obs, e);
      else passed++;
    end
    // Direction change alone must not clear done.
    up = 1'b1; enable = 1'b0;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b1));
    tick();
    #1;
    e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
    if (obs !== e) $display("FAIL done_dirchange: got %h want %h", obs, e);
    else passed++;
    loadn = 1'b0; data = 4'd4;
    exp_q.push_back(mk(4'd4, 1'b0, 1'b0));
    tick();
    loadn = 1'b1;
    #1;
    e = exp_q.pop_front(); obs = {count, tc, zero, at_max, done}; total++;
    if (obs !== e) $display("FAIL done_load_clear: got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_cascade();
    int v = 10;
    up = 1'b0; wrap = 1'b1; cen = 1'b0; loadn_c = 1'b0; data_t = 4'd1; data_u = 4'd0;
    exp_q.push_back(8'h10);
    tick();
    loadn_c = 1'b1; cen = 1'b1;
    #1;
    e = exp_q.pop_front(); obs = {ct, cu}; total++;
    if (obs !== e) $display("FAIL cascade_load: got %h want %h", obs, e);
    else passed++;
    for (int i = 0; i < 11; i++) begin
      v = (v == 0) ? 59 : v - 1;
      exp_q.push_back({4'(v / 10), 4'(v % 10)});
      tick();
      #1;
      e = exp_q.pop_front(); obs = {ct, cu}; total++;
      if (obs !== e) $display("FAIL cascade[%0d]: got %h want %h", i, obs, e);
      else passed++;
    end
    cen = 1'b0;
  endtask

  task automatic test_async_reset();
    up = 1'b0; wrap = 1'b1; enable = 1'b1; loadn = 1'b1;
    exp_q.push_back(mk(4'd2, 1'b0, 1'b0));
    #1;
    e = exp_q.pop_front(); obs = {count2, tc2, zero2, at_max2, done2}; total++;
    if (obs !== e) $display("FAIL rv2_reset: got %h want %h", obs, e);
    else passed++;
    clrn2 = 1'b1; wrap = 1'b0; loadn = 1'b0; data = 4'd0;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd0, 1'b0, 1'b1));
    tick();
    loadn = 1'b1;
    #1;
    e = exp_q.pop_front(); obs = {count2, tc2, zero2, at_max2, done2}; total++;
    if (obs !== e) $display("FAIL rv2_load0: got %h want %h", obs, e);
    else passed++;
    tick();
    #1;
    e = exp_q.pop_front(); obs = {count2, tc2, zero2, at_max2, done2}; total++;
    if (obs !== e) $display("FAIL rv2_done: got %h want %h", obs, e);
    else passed++;
    up = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(mk(4'(i), 1'b0, 1'b1));
      tick();
      #1;
      e = exp_q.pop_front(); obs = {count2, tc2, zero2, at_max2, done2}; total++;
      if (obs !== e) $display("FAIL rv2_up[%0d]: got %h want %h", i, obs, e);
      else passed++;
    end
    // Async reset between edges at count 3.
    #2;
    clrn2 = 1'b0;
    exp_q.push_back(mk(4'd2, 1'b0, 1'b0));
    #1;
    e = exp_q.pop_front(); obs = {count2, tc2, zero2, at_max2, done2}; total++;
    if (obs !== e) $display("FAIL rv2_async: got %h want %h", obs, e);
    else passed++;
    #1;
    clrn2 = 1'b1;
    exp_q.push_back(mk(4'd3, 1'b0, 1'b0));
    tick();
    #1;
    e = exp_q.pop_front(); obs = {count2, tc2, zero2, at_max2, done2}; total++;
    if (obs !== e) $display("FAIL rv2_after_release: got %h want %h", obs, e);
    else passed++;
    clrn2 = 1'b0; loadn = 1'b0; data = 4'd4;
    exp_q.push_back(mk(4'd2, 1'b0, 1'b0));
    tick();
    #1;
    e = exp_q.pop_front(); obs = {count2, tc2, zero2, at_max2, done2}; total++;
    if (obs !== e) $display("FAIL rv2_reset_vs_load: got %h want %h", obs, e);
    else passed++;
    clrn2 = 1'b1; loadn = 1'b1; enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_down_wrap();
    test_up_wrap();
    test_load_clamp();
    test_stop_done();
    test_cascade();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
